// File: rtl/rs_alu_pkg.sv
// Shared types for the ALU reservation station: widths, opsel/ALU codes, entry layout.
// Opsel and ALU function codes are carried opaquely; execute interprets them.
package rs_alu_pkg;

  localparam int WORD     = 32;
  localparam int ADDR_LEN = 32;
  localparam int TAG_W    = 4;

  localparam logic [1:0] OPSEL_RS   = 2'd0;
  localparam logic [1:0] OPSEL_IMM  = 2'd1;
  localparam logic [1:0] OPSEL_PC   = 2'd2;
  localparam logic [1:0] OPSEL_ZERO = 2'd3;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_func_e;

  typedef struct packed {
    logic                busy;
    logic [1:0]          opsel1;
    logic [1:0]          opsel2;
    logic [4:0]          alu_func;
    logic                rs1_rdy;
    logic [TAG_W-1:0]    rs1_tag;
    logic [WORD-1:0]     rs1_value;
    logic                rs2_rdy;
    logic [TAG_W-1:0]    rs2_tag;
    logic [WORD-1:0]     rs2_value;
    logic [WORD-1:0]     imm;
    logic [ADDR_LEN-1:0] pc;
    logic [TAG_W-1:0]    dst_tag;
  } rs_entry_t;

  // True when a waiting operand should capture the current broadcast.
  function automatic logic cdb_hit(input logic rdy, input logic [TAG_W-1:0] tag,
                                   input logic cdb_valid, input logic [TAG_W-1:0] cdb_tag);
    return !rdy && cdb_valid && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_alu_prio_enc.sv
// Lowest-index-set priority encoder; purely combinational.
module rs_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: dispatch into lowest free slot, CDB wakeup, issue lowest ready slot.
// Issue offer is one cycle after operands become ready; disp_ready reflects registered occupancy only.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [4:0]          disp_alu_func,
  input  logic [1:0]          disp_opsel1,
  input  logic [1:0]          disp_opsel2,
  input  logic                disp_rs1_rdy,
  input  logic                disp_rs2_rdy,
  input  logic [TAG_W-1:0]    disp_rs1_tag,
  input  logic [TAG_W-1:0]    disp_rs2_tag,
  input  logic [WORD-1:0]     disp_rs1_value,
  input  logic [WORD-1:0]     disp_rs2_value,
  input  logic [WORD-1:0]     disp_imm,
  input  logic [ADDR_LEN-1:0] disp_pc,
  input  logic [TAG_W-1:0]    disp_dst_tag,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [WORD-1:0]     cdb_value,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [1:0]          iss_opsel1,
  output logic [1:0]          iss_opsel2,
  output logic [4:0]          iss_alu_func,
  output logic [WORD-1:0]     iss_rs1_value,
  output logic [WORD-1:0]     iss_rs2_value,
  output logic [WORD-1:0]     iss_imm,
  output logic [ADDR_LEN-1:0] iss_pc,
  output logic [TAG_W-1:0]    iss_dst_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        new_ent;
  rs_entry_t        sel_ent;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic             free_found;
  logic             rdy_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] rdy_idx;
  logic             disp_fire;
  logic             iss_fire;

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !ent_q[i].busy;
      rdy_vec[i]  = ent_q[i].busy && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
  end

  rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_rdy_sel (
    .req   (rdy_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  assign disp_ready = free_found;
  assign disp_fire  = disp_valid && free_found;
  assign iss_valid  = rdy_found;
  assign iss_fire   = rdy_found && iss_ready;

  // New entry, with same-cycle CDB bypass so a broadcast is never missed at dispatch.
  always_comb begin
    new_ent           = '0;
    new_ent.busy      = 1'b1;
    new_ent.opsel1    = disp_opsel1;
    new_ent.opsel2    = disp_opsel2;
    new_ent.alu_func  = disp_alu_func;
    new_ent.rs1_rdy   = disp_rs1_rdy;
    new_ent.rs1_tag   = disp_rs1_tag;
    new_ent.rs1_value = disp_rs1_value;
    new_ent.rs2_rdy   = disp_rs2_rdy;
    new_ent.rs2_tag   = disp_rs2_tag;
    new_ent.rs2_value = disp_rs2_value;
    new_ent.imm       = disp_imm;
    new_ent.pc        = disp_pc;
    new_ent.dst_tag   = disp_dst_tag;
    if (cdb_hit(disp_rs1_rdy, disp_rs1_tag, cdb_valid, cdb_tag)) begin
      new_ent.rs1_rdy   = 1'b1;
      new_ent.rs1_value = cdb_value;
    end
    if (cdb_hit(disp_rs2_rdy, disp_rs2_tag, cdb_valid, cdb_tag)) begin
      new_ent.rs2_rdy   = 1'b1;
      new_ent.rs2_value = cdb_value;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_hit(ent_q[i].rs1_rdy, ent_q[i].rs1_tag, cdb_valid, cdb_tag)) begin
        ent_d[i].rs1_rdy   = 1'b1;
        ent_d[i].rs1_value = cdb_value;
      end
      if (ent_q[i].busy && cdb_hit(ent_q[i].rs2_rdy, ent_q[i].rs2_tag, cdb_valid, cdb_tag)) begin
        ent_d[i].rs2_rdy   = 1'b1;
        ent_d[i].rs2_value = cdb_value;
      end
    end
    // Issue and dispatch never target the same slot: one is busy, the other free.
    if (iss_fire) ent_d[rdy_idx].busy = 1'b0;
    if (disp_fire) ent_d[free_idx] = new_ent;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    sel_ent       = ent_q[rdy_idx];
    iss_opsel1    = '0;
    iss_opsel2    = '0;
    iss_alu_func  = '0;
    iss_rs1_value = '0;
    iss_rs2_value = '0;
    iss_imm       = '0;
    iss_pc        = '0;
    iss_dst_tag   = '0;
    if (rdy_found) begin
      iss_opsel1    = sel_ent.opsel1;
      iss_opsel2    = sel_ent.opsel2;
      iss_alu_func  = sel_ent.alu_func;
      iss_rs1_value = sel_ent.rs1_value;
      iss_rs2_value = sel_ent.rs2_value;
      iss_imm       = sel_ent.imm;
      iss_pc        = sel_ent.pc;
      iss_dst_tag   = sel_ent.dst_tag;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: hand-computed vectors checked with immediate assertions.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                disp_valid;
  logic                disp_ready;
  logic [4:0]          disp_alu_func;
  logic [1:0]          disp_opsel1;
  logic [1:0]          disp_opsel2;
  logic                disp_rs1_rdy;
  logic                disp_rs2_rdy;
  logic [TAG_W-1:0]    disp_rs1_tag;
  logic [TAG_W-1:0]    disp_rs2_tag;
  logic [WORD-1:0]     disp_rs1_value;
  logic [WORD-1:0]     disp_rs2_value;
  logic [WORD-1:0]     disp_imm;
  logic [ADDR_LEN-1:0] disp_pc;
  logic [TAG_W-1:0]    disp_dst_tag;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [WORD-1:0]     cdb_value;
  logic                iss_valid;
  logic                iss_ready;
  logic [1:0]          iss_opsel1;
  logic [1:0]          iss_opsel2;
  logic [4:0]          iss_alu_func;
  logic [WORD-1:0]     iss_rs1_value;
  logic [WORD-1:0]     iss_rs2_value;
  logic [WORD-1:0]     iss_imm;
  logic [ADDR_LEN-1:0] iss_pc;
  logic [TAG_W-1:0]    iss_dst_tag;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rs_alu #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_alu_func  (disp_alu_func),
    .disp_opsel1    (disp_opsel1),
    .disp_opsel2    (disp_opsel2),
    .disp_rs1_rdy   (disp_rs1_rdy),
    .disp_rs2_rdy   (disp_rs2_rdy),
    .disp_rs1_tag   (disp_rs1_tag),
    .disp_rs2_tag   (disp_rs2_tag),
    .disp_rs1_value (disp_rs1_value),
    .disp_rs2_value (disp_rs2_value),
    .disp_imm       (disp_imm),
    .disp_pc        (disp_pc),
    .disp_dst_tag   (disp_dst_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_opsel1     (iss_opsel1),
    .iss_opsel2     (iss_opsel2),
    .iss_alu_func   (iss_alu_func),
    .iss_rs1_value  (iss_rs1_value),
    .iss_rs2_value  (iss_rs2_value),
    .iss_imm        (iss_imm),
    .iss_pc         (iss_pc),
    .iss_dst_tag    (iss_dst_tag)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_disp();
    disp_valid     = 1'b0;
    disp_alu_func  = '0;
    disp_opsel1    = '0;
    disp_opsel2    = '0;
    disp_rs1_rdy   = 1'b0;
    disp_rs2_rdy   = 1'b0;
    disp_rs1_tag   = '0;
    disp_rs2_tag   = '0;
    disp_rs1_value = '0;
    disp_rs2_value = '0;
    disp_imm       = '0;
    disp_pc        = '0;
    disp_dst_tag   = '0;
  endtask

  task automatic idle_cdb();
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_value = '0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [WORD-1:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
  endtask

  // imm and pc are derived from dst so the bench can predict them.
  task automatic disp(input logic r1, input logic [TAG_W-1:0] t1, input logic [WORD-1:0] v1,
                      input logic r2, input logic [TAG_W-1:0] t2, input logic [WORD-1:0] v2,
                      input logic [TAG_W-1:0] dst);
    disp_valid     = 1'b1;
    disp_alu_func  = ALU_ADD;
    disp_opsel1    = OPSEL_RS;
    disp_opsel2    = OPSEL_RS;
    disp_rs1_rdy   = r1;
    disp_rs1_tag   = t1;
    disp_rs1_value = v1;
    disp_rs2_rdy   = r2;
    disp_rs2_tag   = t2;
    disp_rs2_value = v2;
    disp_imm       = 32'h100 + 32'(dst);
    disp_pc        = 32'h1000 + 32'(dst) * 4;
    disp_dst_tag   = dst;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    iss_ready = 1'b0;
    idle_disp();
    idle_cdb();
    tick();
    tick();
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_rs1", 64'(iss_rs1_value), 64'd0);
    chk("rst_iss_pc", 64'(iss_pc), 64'd0);
    chk("rst_iss_dst", 64'(iss_dst_tag), 64'd0);
    rst = 1'b0;
    tick();

    // Ready dispatch: issue offered the next cycle, gone the cycle after.
    iss_ready = 1'b1;
    disp(1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd3);
    disp_alu_func = ALU_SUB;
    disp_opsel1   = OPSEL_PC;
    disp_opsel2   = OPSEL_IMM;
    tick();
    idle_disp();
    chk("rdy_valid", 64'(iss_valid), 64'd1);
    chk("rdy_rs1", 64'(iss_rs1_value), 64'd5);
    chk("rdy_rs2", 64'(iss_rs2_value), 64'd7);
    chk("rdy_dst", 64'(iss_dst_tag), 64'd3);
    chk("rdy_func", 64'(iss_alu_func), 64'(ALU_SUB));
    chk("rdy_opsel1", 64'(iss_opsel1), 64'(OPSEL_PC));
    chk("rdy_opsel2", 64'(iss_opsel2), 64'(OPSEL_IMM));
    chk("rdy_imm", 64'(iss_imm), 64'h103);
    chk("rdy_pc", 64'(iss_pc), 64'h100c);
    tick();
    chk("rdy_gone", 64'(iss_valid), 64'd0);

    // Wakeup: rs1 waits on tag 9, broadcast three cycles after dispatch.
    disp(1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2, 4'd4);
    tick();
    idle_disp();
    chk("wk_t1", 64'(iss_valid), 64'd0);
    tick();
    chk("wk_t2", 64'(iss_valid), 64'd0);
    tick();
    cdb(4'd9, 32'hDEAD);
    chk("wk_t3_no_comb", 64'(iss_valid), 64'd0);
    tick();
    idle_cdb();
    chk("wk_t4_valid", 64'(iss_valid), 64'd1);
    chk("wk_t4_rs1", 64'(iss_rs1_value), 64'hDEAD);
    chk("wk_t4_rs2", 64'(iss_rs2_value), 64'd2);
    chk("wk_t4_dst", 64'(iss_dst_tag), 64'd4);
    tick();
    chk("wk_gone", 64'(iss_valid), 64'd0);

    // Dispatch-cycle bypass on rs2.
    disp(1'b1, 4'd0, 32'h22, 1'b0, 4'd2, 32'd0, 4'd5);
    cdb(4'd2, 32'h11);
    tick();
    idle_disp();
    idle_cdb();
    chk("byp_valid", 64'(iss_valid), 64'd1);
    chk("byp_rs1", 64'(iss_rs1_value), 64'h22);
    chk("byp_rs2", 64'(iss_rs2_value), 64'h11);
    tick();
    chk("byp_gone", 64'(iss_valid), 64'd0);

    // Both operands woken by a single broadcast.
    disp(1'b0, 4'd12, 32'd0, 1'b0, 4'd12, 32'd0, 4'd6);
    tick();
    idle_disp();
    cdb(4'd12, 32'h77);
    tick();
    idle_cdb();
    chk("dual_rs1", 64'(iss_rs1_value), 64'h77);
    chk("dual_rs2", 64'(iss_rs2_value), 64'h77);
    tick();

    // Fill with issue blocked; fifth dispatch must be dropped.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'd1, 4'(8 + i));
      tick();
    end
    chk("full_ready", 64'(disp_ready), 64'd0);
    chk("full_dst", 64'(iss_dst_tag), 64'd8);
    disp(1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9, 4'd12);
    tick();
    idle_disp();
    chk("full_hold_ready", 64'(disp_ready), 64'd0);
    chk("full_hold_dst", 64'(iss_dst_tag), 64'd8);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk("full_freed", 64'(disp_ready), 64'd1);
    chk("full_next_dst", 64'(iss_dst_tag), 64'd9);
    iss_ready = 1'b1;
    tick();
    chk("drain_dst10", 64'(iss_dst_tag), 64'd10);
    tick();
    chk("drain_dst11", 64'(iss_dst_tag), 64'd11);
    tick();
    chk("drain_empty", 64'(iss_valid), 64'd0);

    // Priority: slots 0..3 wait on tags 14, 4, 15, 6.
    disp(1'b0, 4'd14, 32'd0, 1'b1, 4'd0, 32'd0, 4'd0);
    tick();
    disp(1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd0, 4'd1);
    tick();
    disp(1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'd0, 4'd2);
    tick();
    disp(1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd0, 4'd3);
    tick();
    idle_disp();
    chk("pri_none", 64'(iss_valid), 64'd0);
    cdb(4'd6, 32'h66);
    tick();
    cdb(4'd4, 32'h44);
    chk("pri_first_dst", 64'(iss_dst_tag), 64'd3);
    chk("pri_first_rs1", 64'(iss_rs1_value), 64'h66);
    tick();
    idle_cdb();
    chk("pri_second_dst", 64'(iss_dst_tag), 64'd1);
    chk("pri_second_rs1", 64'(iss_rs1_value), 64'h44);
    tick();
    chk("pri_drained", 64'(iss_valid), 64'd0);

    // Refill slots 1 and 3, make both ready, then let them issue.
    iss_ready = 1'b0;
    disp(1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd0, 4'd1);
    tick();
    disp(1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd0, 4'd3);
    tick();
    idle_disp();
    cdb(4'd4, 32'h4);
    tick();
    cdb(4'd6, 32'h6);
    tick();
    idle_cdb();
    chk("pri_both_dst", 64'(iss_dst_tag), 64'd1);
    iss_ready = 1'b1;
    tick();
    chk("pri_both_next", 64'(iss_dst_tag), 64'd3);
    tick();
    chk("pri_both_done", 64'(iss_valid), 64'd0);

    // Flush: slots 0, 1, 2 busy, flushed together with a ready dispatch.
    disp(1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd0, 4'd7);
    tick();
    disp(1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_disp();
    chk("fl_iss_valid", 64'(iss_valid), 64'd0);
    chk("fl_disp_ready", 64'(disp_ready), 64'd1);
    chk("fl_iss_dst", 64'(iss_dst_tag), 64'd0);
    cdb(4'd14, 32'hE);
    tick();
    cdb(4'd7, 32'h7);
    tick();
    idle_cdb();
    chk("fl_old_tag14", 64'(iss_valid), 64'd0);
    tick();
    chk("fl_old_tag7", 64'(iss_valid), 64'd0);

    // Reset mid-operation drops a pending ready entry.
    iss_ready = 1'b0;
    disp(1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3, 4'd9);
    tick();
    idle_disp();
    chk("mid_pre_valid", 64'(iss_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(iss_valid), 64'd0);
    chk("mid_rst_rs1", 64'(iss_rs1_value), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station feeding the execute stage's ALU. It accepts dispatched micro-ops whose source operands may still be pending. It captures pending operands from the common data bus (CDB). It issues one fully-ready micro-op per cycle to execute, delivering operand-select codes, ALU function, operand values, immediate and PC.

## Interface
- WORD, 32, data width
- ADDR_LEN, 32, PC width
- TAG_W, 4, physical/ROB tag width
- DEPTH, 4, entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_alu_func  in  5  ALU function
- disp_opsel1, disp_opsel2  in  2 each  operand-select codes, passed through
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand value valid at dispatch
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  producer tag if not ready
- disp_rs1_value, disp_rs2_value  in  WORD each  value if ready
- disp_imm  in  WORD  immediate
- disp_pc  in  ADDR_LEN  instruction PC
- disp_dst_tag  in  TAG_W  result tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  WORD  broadcast value
- iss_valid  out  1  issue offer
- iss_ready  in  1  execute accepts
- iss_opsel1, iss_opsel2  out  2 each
- iss_alu_func  out  5
- iss_rs1_value, iss_rs2_value, iss_imm  out  WORD each
- iss_pc  out  ADDR_LEN
- iss_dst_tag  out  TAG_W

## Operation
- Each entry holds: busy, opsel1/2, alu_func, per operand {rdy, tag, value}, imm, pc, dst_tag.
- Dispatch fires on disp_valid && disp_ready. Writes the lowest-index non-busy entry.
- disp_ready = 1 iff at least one entry is non-busy at the start of the cycle. A slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch-time CDB bypass: if operand not ready and cdb_valid && cdb_tag == operand tag in the dispatch cycle, the entry stores rdy=1 and value=cdb_value.
- CDB wakeup: every busy entry with a non-ready operand whose tag matches cdb_tag when cdb_valid sets rdy=1 and captures cdb_value. Both operands of one entry may wake on the same broadcast.
- Issue select: the lowest-index busy entry with both operands rdy (registered state only). iss_* outputs are driven combinationally from that entry. iss_valid = 1 if such an entry exists.
- Issue fires on iss_valid && iss_ready. The selected entry's busy is cleared at the clock edge.
- iss_* fields stay stable while iss_valid && !iss_ready, unless a lower-index entry becomes ready. Execute must not depend on the offer being stable.
- Flush clears every busy bit. Flush beats a dispatch and an issue in the same cycle: neither takes effect, and execute must ignore an issue in a flush cycle.
- opsel and alu_func are opaque here and are passed through unmodified.

## Timing
- Reset: all busy=0. Outputs after reset: disp_ready=1, iss_valid=0, all other iss_* = 0 (outputs zeroed when iss_valid=0).
- Dispatch with both operands ready at cycle t → iss_valid at t+1.
- CDB wakeup at cycle t → issuable at t+1. There is no CDB-to-issue combinational path.
- Throughput: 1 dispatch and 1 issue per cycle sustained.
- Full: with DEPTH busy and no issue, disp_ready=0. It returns to 1 the cycle after an issue fires.
- Reset mid-operation has the same effect as flush plus output zeroing.

## Structure
- Shared package: TAG_W, the opsel code constants (e.g. OPSEL_RS, OPSEL_IMM, OPSEL_PC, OPSEL_ZERO), alu_func encodings, and a packed rs-entry struct.
- One sub-module: rs_prio_enc, a parameterized lowest-index-set priority encoder. It is used twice: free-slot select and ready-entry select.

## Test plan
- Ready dispatch: dispatch rs1=5, rs2=7, func ADD, dst=3 at t; iss_ready=1 → at t+1 iss_valid=1 with values 5/7 and dst_tag 3; at t+2 iss_valid=0.
- Wakeup: dispatch with rs1 tag 9 not ready. CDB tag 9 value 0xDEAD at t+3 → issue at t+4 with rs1=0xDEAD. No issue before t+4.
- Dispatch bypass: dispatch rs2 tag 2 not ready, with CDB tag 2 value 0x11 in the same cycle → issue next cycle with rs2=0x11.
- Fill/backpressure: hold iss_ready=0 and dispatch 4 entries → disp_ready=0 and the 5th dispatch is ignored. Raise iss_ready for one cycle → entry 0 issues, and disp_ready=1 the following cycle.
- Priority: entries 1 and 3 wait on tags 4 and 6. CDB tag 6, then tag 4 → entry 3 issues first, then entry 1. With both ready together, entry 1 issues before entry 3.
- Flush: 3 busy entries plus a concurrent dispatch and flush → next cycle iss_valid=0, disp_ready=1, and a later CDB match on the old tags produces no issue.
